// File: rtl/trace_pkg.sv
// Shared constants, FSM encoding and entry layout
// for the trace ping-pong buffer.
package trace_pkg;

  localparam int TRACE_COLUMNS = 640;
  localparam int TRACE_ADDR_W  = 10;
  localparam int TRACE_VDIST_W = 16;
  localparam int TRACE_SIDE_W  = 1;
  localparam int TRACE_TEX_W   = 6;
  localparam int TRACE_ENTRY_W =
    TRACE_VDIST_W + TRACE_SIDE_W + TRACE_TEX_W;

  typedef enum logic [1:0] {
    ST_FILLING = 2'd0,
    ST_FULL    = 2'd1,
    ST_SWAP    = 2'd2
  } trace_state_e;

  typedef struct packed {
    logic [TRACE_VDIST_W-1:0] vdist;
    logic                     side;
    logic [TRACE_TEX_W-1:0]   tex;
  } trace_entry_t;

endpackage

// File: rtl/trace_pingpong_buffer_if.sv
// Tracer write port, renderer read port and
// frame-swap status of the trace buffer.
interface trace_pingpong_buffer_if
  import trace_pkg::*;
#(
  parameter int ADDR_W  = TRACE_ADDR_W,
  parameter int VDIST_W = TRACE_VDIST_W,
  parameter int TEX_W   = TRACE_TEX_W
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_column;
  logic [VDIST_W-1:0] wr_vdist;
  logic               wr_side;
  logic [TEX_W-1:0]   wr_tex;
  logic               wr_done;
  logic               wr_ready;
  logic               swap_req;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_column;
  logic [VDIST_W-1:0] rd_vdist;
  logic               rd_side;
  logic [TEX_W-1:0]   rd_tex;
  logic               rd_valid;
  logic               front_valid;
  logic               swapped;
  logic               err;

  modport master (
    output wr_en, wr_column, wr_vdist,
    output wr_side, wr_tex, wr_done,
    output swap_req, rd_en, rd_column,
    input  wr_ready, rd_vdist, rd_side,
    input  rd_tex, rd_valid, front_valid,
    input  swapped, err
  );

  modport slave (
    input  wr_en, wr_column, wr_vdist,
    input  wr_side, wr_tex, wr_done,
    input  swap_req, rd_en, rd_column,
    output wr_ready, rd_vdist, rd_side,
    output rd_tex, rd_valid, front_valid,
    output swapped, err
  );
endinterface

// File: rtl/trace_bank.sv
// One bank of trace entries: synchronous write,
// registered read. Contents are not reset.
module trace_bank #(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10,
  parameter int W      = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [W-1:0]      wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [W-1:0]      rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/trace_pingpong_buffer.sv
// Double-buffered per-column trace store; define
// TRACE_BUFFER_DOUBLE_EN for two banks, else one shared bank.
module trace_pingpong_buffer
  import trace_pkg::*;
#(
  parameter int COLUMNS = TRACE_COLUMNS,
  parameter int ADDR_W  = TRACE_ADDR_W,
  parameter int VDIST_W = TRACE_VDIST_W,
  parameter int TEX_W   = TRACE_TEX_W
) (
  input logic clk,
  input logic reset_n,
  trace_pingpong_buffer_if.slave bus
);
  localparam int EW = VDIST_W + 1 + TEX_W;
  localparam logic [ADDR_W:0] COLS =
    (ADDR_W+1)'(COLUMNS);
`ifdef TRACE_BUFFER_DOUBLE_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  trace_state_e state_q;
  logic wr_ready_q, front_valid_q;
  logic swapped_q, err_q, err_d;
  logic rd_valid_q, rd_oob_q;
  logic wr_in, rd_in, wr_ok, rd_ok;
  logic [NB-1:0] we_b;
  logic [EW-1:0] wdata, rd_word;
  logic [EW-1:0] rdata [NB];

  assign wr_in = {1'b0, bus.wr_column} < COLS;
  assign rd_in = {1'b0, bus.rd_column} < COLS;
  assign wr_ok = bus.wr_en && wr_in &&
                 (state_q == ST_FILLING);
  assign rd_ok = bus.rd_en && rd_in;
  assign err_d = err_q
    | (bus.wr_en && !(wr_in && state_q == ST_FILLING))
    | (bus.rd_en && !rd_in);
  assign wdata = {bus.wr_vdist, bus.wr_side, bus.wr_tex};

`ifdef TRACE_BUFFER_DOUBLE_EN
  logic bank_sel_q, rd_sel_q;
  // Back bank is the one not being displayed.
  assign we_b    = {wr_ok & ~bank_sel_q, wr_ok & bank_sel_q};
  assign rd_word = rd_oob_q ? '0 : rdata[rd_sel_q];
`else
  assign we_b    = wr_ok;
  assign rd_word = rd_oob_q ? '0 : rdata[0];
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    trace_bank #(
      .DEPTH (COLUMNS),
      .ADDR_W(ADDR_W),
      .W     (EW)
    ) u_bank (
      .clk    (clk),
      .rst_n  (reset_n),
      .we_i   (we_b[b]),
      .waddr_i(bus.wr_column),
      .wdata_i(wdata),
      .re_i   (rd_ok),
      .raddr_i(bus.rd_column),
      .rdata_o(rdata[b])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_FILLING;
      wr_ready_q    <= 1'b1;
      front_valid_q <= 1'b0;
      swapped_q     <= 1'b0;
      err_q         <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_oob_q      <= 1'b0;
`ifdef TRACE_BUFFER_DOUBLE_EN
      bank_sel_q    <= 1'b0;
      rd_sel_q      <= 1'b0;
`endif
    end else begin
      swapped_q  <= 1'b0;
      err_q      <= err_d;
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_oob_q <= !rd_in;
`ifdef TRACE_BUFFER_DOUBLE_EN
        // Latch the front bank at request time so a
        // read during SWAP still returns old-front data.
        rd_sel_q <= bank_sel_q;
`endif
      end
      unique case (state_q)
        ST_FILLING: begin
          if (bus.wr_done) begin
            state_q    <= ST_FULL;
            wr_ready_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (bus.swap_req) state_q <= ST_SWAP;
        end
        ST_SWAP: begin
          state_q       <= ST_FILLING;
          wr_ready_q    <= 1'b1;
          front_valid_q <= 1'b1;
          swapped_q     <= 1'b1;
`ifdef TRACE_BUFFER_DOUBLE_EN
          bank_sel_q    <= ~bank_sel_q;
`endif
        end
        default: begin
          state_q    <= ST_FILLING;
          wr_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_ready    = wr_ready_q;
  assign bus.front_valid = front_valid_q;
  assign bus.swapped     = swapped_q;
  assign bus.err         = err_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_vdist    = rd_word[EW-1 -: VDIST_W];
  assign bus.rd_side     = rd_word[TEX_W];
  assign bus.rd_tex      = rd_word[TEX_W-1:0];
endmodule

// File: tb/tb_trace_pingpong_buffer.sv
// Directed checks for trace_pingpong_buffer in
// either bank configuration.
module tb_trace_pingpong_buffer;
  import trace_pkg::*;

`ifdef TRACE_BUFFER_DOUBLE_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  trace_pingpong_buffer_if bus_if ();

  trace_pingpong_buffer dut (
    .clk    (clk),
    .reset_n(rst_n),
    .bus    (bus_if.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int col, input int vd,
                    input bit sd, input int tx);
    bus_if.wr_en     = 1'b1;
    bus_if.wr_column = 10'(col);
    bus_if.wr_vdist  = 16'(vd);
    bus_if.wr_side   = sd;
    bus_if.wr_tex    = 6'(tx);
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic rd(input int col);
    bus_if.rd_en     = 1'b1;
    bus_if.rd_column = 10'(col);
    tick();
    bus_if.rd_en = 1'b0;
  endtask

  task automatic pulse_done();
    bus_if.wr_done = 1'b1;
    tick();
    bus_if.wr_done = 1'b0;
  endtask

  task automatic pulse_swap();
    bus_if.swap_req = 1'b1;
    tick();
    bus_if.swap_req = 1'b0;
  endtask

  initial begin
    bus_if.wr_en     = 1'b0;
    bus_if.wr_column = '0;
    bus_if.wr_vdist  = '0;
    bus_if.wr_side   = 1'b0;
    bus_if.wr_tex    = '0;
    bus_if.wr_done   = 1'b0;
    bus_if.swap_req  = 1'b0;
    bus_if.rd_en     = 1'b0;
    bus_if.rd_column = '0;

    // reset state
    repeat (2) tick();
    check("rst_wr_ready", 32'(bus_if.wr_ready), 1);
    check("rst_front_valid", 32'(bus_if.front_valid), 0);
    check("rst_swapped", 32'(bus_if.swapped), 0);
    check("rst_rd_valid", 32'(bus_if.rd_valid), 0);
    check("rst_rd_vdist", 32'(bus_if.rd_vdist), 0);
    check("rst_err", 32'(bus_if.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    rd(5);
    check("rd5_valid", 32'(bus_if.rd_valid), 1);
    check("rd5_front_valid", 32'(bus_if.front_valid), 0);
    check("rd5_err", 32'(bus_if.err), 0);
    check("rd5_wr_ready", 32'(bus_if.wr_ready), 1);
    tick();
    check("rd_valid_drop", 32'(bus_if.rd_valid), 0);

    // frame 1
    for (int c = 0; c < 640; c++) wr(c, c, c[0], c % 64);
    pulse_done();
    check("full_wr_ready", 32'(bus_if.wr_ready), 0);
    pulse_swap();
    check("swap_cycle_pulse", 32'(bus_if.swapped), 0);
    tick();
    check("f1_swapped", 32'(bus_if.swapped), 1);
    check("f1_front_valid", 32'(bus_if.front_valid), 1);
    check("f1_wr_ready", 32'(bus_if.wr_ready), 1);
    tick();
    check("f1_swapped_drop", 32'(bus_if.swapped), 0);
    rd(100);
    check("f1_vdist", 32'(bus_if.rd_vdist), 100);
    check("f1_side", 32'(bus_if.rd_side), 0);
    check("f1_tex", 32'(bus_if.rd_tex), 36);
    rd(101);
    check("f1_side101", 32'(bus_if.rd_side), 1);

    // incomplete frame: swap ignored
    wr(100, 'h1234, 1'b1, 5);
    pulse_swap();
    tick();
    check("f2_no_swap", 32'(bus_if.swapped), 0);
    check("f2_wr_ready", 32'(bus_if.wr_ready), 1);
    rd(100);
    check("f2_old_front", 32'(bus_if.rd_vdist),
          DBL ? 32'd100 : 32'h1234);
    pulse_done();
    pulse_swap();
    rd(100);
    check("f2_rd_in_swap", 32'(bus_if.rd_vdist),
          DBL ? 32'd100 : 32'h1234);
    check("f2_swapped", 32'(bus_if.swapped), 1);
    rd(100);
    check("f2_vdist", 32'(bus_if.rd_vdist), 'h1234);
    check("f2_side", 32'(bus_if.rd_side), 1);
    check("f2_tex", 32'(bus_if.rd_tex), 5);

    // wr_en + wr_done + swap_req together
    bus_if.wr_en     = 1'b1;
    bus_if.wr_column = 10'd200;
    bus_if.wr_vdist  = 16'hABCD;
    bus_if.wr_side   = 1'b0;
    bus_if.wr_tex    = 6'd8;
    bus_if.wr_done   = 1'b1;
    bus_if.swap_req  = 1'b1;
    tick();
    bus_if.wr_en    = 1'b0;
    bus_if.wr_done  = 1'b0;
    bus_if.swap_req = 1'b0;
    check("f3_full", 32'(bus_if.wr_ready), 0);
    tick();
    check("f3_no_swap", 32'(bus_if.swapped), 0);
    check("f3_still_full", 32'(bus_if.wr_ready), 0);
    pulse_swap();
    tick();
    check("f3_swapped", 32'(bus_if.swapped), 1);
    rd(200);
    check("f3_vdist200", 32'(bus_if.rd_vdist), 'hABCD);
    rd(100);
    check("f3_vdist100", 32'(bus_if.rd_vdist),
          DBL ? 32'd100 : 32'h1234);

    // range errors
    check("err_clear", 32'(bus_if.err), 0);
    wr(640, 'h5555, 1'b1, 1);
    check("err_wr_oob", 32'(bus_if.err), 1);
    rd(700);
    check("oob_rd_valid", 32'(bus_if.rd_valid), 1);
    check("oob_rd_vdist", 32'(bus_if.rd_vdist), 0);
    check("oob_rd_side", 32'(bus_if.rd_side), 0);
    check("oob_rd_tex", 32'(bus_if.rd_tex), 0);
    tick();
    check("err_sticky", 32'(bus_if.err), 1);
    check("oob_hold", 32'(bus_if.rd_vdist), 0);

    // reset mid-fill
    for (int c = 250; c <= 300; c++) wr(c, c, 1'b0, 0);
    rst_n = 1'b0;
    #2;
    check("mrst_wr_ready", 32'(bus_if.wr_ready), 1);
    check("mrst_front_valid", 32'(bus_if.front_valid), 0);
    check("mrst_err", 32'(bus_if.err), 0);
    check("mrst_rd_valid", 32'(bus_if.rd_valid), 0);
    check("mrst_rd_vdist", 32'(bus_if.rd_vdist), 0);
    check("mrst_swapped", 32'(bus_if.swapped), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(100);
    check("mrst_bank_sel0", 32'(bus_if.rd_vdist), 'h1234);
`ifndef TRACE_BUFFER_DOUBLE_EN
    wr(7, 77, 1'b1, 3);
    rd(7);
    check("single_rd7", 32'(bus_if.rd_vdist), 77);
`endif
    pulse_done();
    check("full_err0", 32'(bus_if.err), 0);
    wr(8, 1, 1'b0, 0);
    check("full_wr_err", 32'(bus_if.err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/trace_pingpong_buffer.md
# trace_pingpong_buffer

Double-buffered, parametrised store for per-column ray-trace results (view distance, wall side, texture ID). The tracer fills the back bank during a frame while the renderer repeatedly reads the front bank for every scanline. Banks swap on a frame-boundary request only once the back bank is complete. Separate write and read ports replace the old shared bi-directional bus.

## Interface
Parameters:
- COLUMNS, 640, number of trace entries per bank
- ADDR_W, 10, column address width; must satisfy 2^ADDR_W ≥ COLUMNS
- VDIST_W, 16, view distance width (Q7.9 at default)
- TEX_W, 6, texture ID width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write the entry on wr_* into the back bank
- wr_column  in  ADDR_W  back-bank write address
- wr_vdist / wr_side / wr_tex  in  VDIST_W / 1 / TEX_W  entry fields
- wr_done  in  1  one-cycle pulse: tracer has finished the back bank
- wr_ready  out  1  back bank is accepting writes (state FILLING)
- swap_req  in  1  one-cycle pulse at the frame boundary (start of vblank)
- rd_en  in  1  read request from the front bank
- rd_column  in  ADDR_W  front-bank read address
- rd_vdist / rd_side / rd_tex  out  VDIST_W / 1 / TEX_W  registered read data
- rd_valid  out  1  rd_* holds data for the request made on the previous cycle
- front_valid  out  1  front bank holds a completed frame
- swapped  out  1  one-cycle pulse on the cycle after a swap
- err  out  1  sticky: out-of-range access, or a write while not FILLING

## Operation
- bank_sel (1 bit) selects the front bank. The back bank is !bank_sel.
- Back-bank FSM:
  - FILLING: wr_en with wr_column < COLUMNS writes the back bank. wr_done → FULL.
  - FULL: writes are dropped and set err. swap_req → SWAP.
  - SWAP: toggle bank_sel, set front_valid, pulse swapped, return to FILLING next cycle.
- swap_req while FILLING is ignored. The renderer keeps the old front bank, and the frame is repeated.
- Reads always address the front bank. rd_column ≥ COLUMNS returns all-zero fields, still asserts rd_valid, and sets err.
- Write with wr_column ≥ COLUMNS: dropped, err set.
- Simultaneous wr_done and swap_req in FILLING: state goes to FULL only. The swap waits for the next swap_req.
- Simultaneous wr_en and wr_done in FILLING: the write lands, then the state goes to FULL.
- A read in the same cycle as the SWAP state returns old-front data. Reads issued from the following cycle see the new front bank.
- err clears only on reset.

## Timing
- Write: the entry is stored on the clk edge where wr_en is sampled.
- Read latency is 1 cycle. rd_* and rd_valid update on the edge after rd_en. Without rd_en, rd_* hold their value and rd_valid is 0.
- Swap: swap_req sampled in FULL → SWAP for 1 cycle → swapped pulse. Minimum 2 cycles from swap_req to the next accepted write.
- Reset values: bank_sel=0, state FILLING, wr_ready=1, front_valid=0, swapped=0, rd_valid=0, rd_vdist/rd_side/rd_tex=0, err=0.
- Memory contents are not reset.
- Reset asserted mid-frame aborts immediately. Partial back-bank data is discarded logically, and front_valid drops to 0.

## Configuration
- TRACE_BUFFER_DOUBLE_EN defined: two banks, behaviour as above.
- Undefined: a single bank, shared by both ports.
  - bank_sel is fixed at 0. Read and write address the same memory; a same-column same-cycle read returns old data.
  - The FSM is still present, but SWAP does not toggle a bank. It only sets front_valid and pulses swapped.
  - Halves memory; tearing is acceptable.

## Structure
- Package trace_pkg: default COLUMNS/ADDR_W/VDIST_W/TEX_W constants, entry field widths, FSM state encoding (FILLING, FULL, SWAP), and a packed trace-entry typedef of VDIST_W+1+TEX_W bits.
- Sub-module trace_bank: single-bank synchronous RAM, one write port and one registered read port, COLUMNS × entry width. Instantiated twice, or once when TRACE_BUFFER_DOUBLE_EN is undefined.
- The top level holds the FSM, bank_sel, range checks, the output mux and err.

## Test plan
- Reset then read column 5 → rd_valid=1 next cycle, front_valid=0, err=0, wr_ready=1.
- Fill columns 0–639 with vdist=column, side=column[0], tex=column[5:0]; wr_done; swap_req → swapped pulse, front_valid=1. Read column 100 → vdist=100, side=0, tex=36.
- Next frame: write column 100 with vdist=16'h1234, no wr_done, swap_req → no swap, and column 100 still reads 100. Then wr_done, swap_req → reads 16'h1234.
- wr_done and swap_req on the same cycle → state FULL, no swap. The next swap_req swaps.
- Write to column 640 and read column 700 → write dropped, read returns 0, err=1 sticky. A write in FULL also sets err.
- Assert reset_n low mid-fill (column 300) → all outputs at reset values next edge, bank_sel=0. Without TRACE_BUFFER_DOUBLE_EN, a write to column 7 reads back before any swap.
